// File: rtl/dmtd_pkg.sv
// Shared definitions for the DMTD phase measurement slice.
// Holds the measurement FSM state encoding and the default sizing constants
// used by the front end (synchronizer depth) and the phase meter.
package dmtd_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMeas = 1'b1
  } dmtd_state_e;

  localparam int unsigned DefCntW        = 16;
  localparam int unsigned DefDeglitchLen = 4;
  // Flop depth of the front-end synchronizers feeding dmtd_in.
  localparam int unsigned SyncDepth      = 2;

endpackage

// File: rtl/dmtd_phase_meter_if.sv
// Result channel from the phase meter to the downstream phase/frequency logic.
//   meas_period  cycles between consecutive filtered rising edges
//   meas_high    filtered-high cycles within that period
//   meas_valid   result valid, held until accepted
//   meas_ready   downstream accepts when meas_valid & meas_ready
// master: the phase meter (producer); slave: the consumer.
interface dmtd_phase_meter_if import dmtd_pkg::*; #(
  parameter int unsigned CNT_W = DefCntW
) ();

  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             meas_ready;

  modport master (
    output meas_period,
    output meas_high,
    output meas_valid,
    input  meas_ready
  );

  modport slave (
    input  meas_period,
    input  meas_high,
    input  meas_valid,
    output meas_ready
  );

endinterface

// File: rtl/dmtd_deglitch.sv
// Beat deglitcher: the filtered level follows din only after din has differed
// from it for DEGLITCH_LEN consecutive cycles; any break restarts the count.
//   clk, rst_n  clock, asynchronous active-low reset
//   din         synchronized raw beat
//   filt        filtered beat level
//   rise        one-cycle strobe on a filtered rising edge
module dmtd_deglitch import dmtd_pkg::*; #(
  parameter int unsigned DEGLITCH_LEN = DefDeglitchLen
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt,
  output logic rise
);

  localparam int unsigned     CntW    = $clog2(DEGLITCH_LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEGLITCH_LEN - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] stab_q, stab_d;
  logic            filt_q, filt_d;
  logic            filt_prev_q;

  always_comb begin
    stab_d = '0;
    filt_d = filt_q;
    if (din != filt_q) begin
      if (stab_q == CntLast) begin
        filt_d = ~filt_q;
      end else begin
        stab_d = stab_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q      <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      stab_q      <= stab_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign filt = filt_q;
  assign rise = filt_q & ~filt_prev_q;

endmodule

// File: rtl/dmtd_phase_meter.sv
// DMTD phase meter: deglitches the XOR beat, counts total and high cycles of
// each filtered beat period and hands {period, high} downstream over a
// valid/ready channel with a single holding register.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          measurement enable (deglitcher runs regardless)
//   dmtd_in     synchronized XOR beat
//   meas        result channel (master side)
//   overrun     pulse: result dropped because the holding register was full
//   timeout     pulse: period counter saturated, measurement abandoned
module dmtd_phase_meter import dmtd_pkg::*; #(
  parameter int unsigned CNT_W        = DefCntW,
  parameter int unsigned DEGLITCH_LEN = DefDeglitchLen
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                dmtd_in,
  dmtd_phase_meter_if.master  meas,
  output logic                overrun,
  output logic                timeout
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic filt, rise;

  dmtd_deglitch #(
    .DEGLITCH_LEN(DEGLITCH_LEN)
  ) u_deglitch (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (dmtd_in),
    .filt (filt),
    .rise (rise)
  );

  dmtd_state_e      state_q;
  logic [CNT_W-1:0] period_cnt_q, high_cnt_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic             valid_q, overrun_q, timeout_q;
  logic             emit;

  // A rise while measuring closes the current period with pre-increment counts.
  assign emit = en && (state_q == StMeas) && rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;

      if (!en) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              period_cnt_q <= CntOne;
              high_cnt_q   <= CntOne;
              state_q      <= StMeas;
            end
          end
          StMeas: begin
            if (rise) begin
              period_cnt_q <= CntOne;
              high_cnt_q   <= CntOne;
            end else if (period_cnt_q == CntMax) begin
              timeout_q <= 1'b1;
              state_q   <= StIdle;
            end else begin
              period_cnt_q <= period_cnt_q + CntOne;
              high_cnt_q   <= high_cnt_q + CNT_W'(filt);
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // Holding register: a full, unaccepted register drops the new result.
      if (emit) begin
        if (!valid_q || meas.meas_ready) begin
          period_q <= period_cnt_q;
          high_q   <= high_cnt_q;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (meas.meas_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign meas.meas_period = period_q;
  assign meas.meas_high   = high_q;
  assign meas.meas_valid  = valid_q;
  assign overrun          = overrun_q;
  assign timeout          = timeout_q;

endmodule

// File: tb/tb_dmtd_phase_meter.sv
module tb_dmtd_phase_meter;

  localparam int unsigned W = 8;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic en      = 1'b0;
  logic dmtd_in = 1'b0;
  logic overrun, timeout;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int ov_cnt = 0;
  int to_cnt = 0;

  logic [31:0] q[$];

  dmtd_phase_meter_if #(.CNT_W(W)) mif ();

  dmtd_phase_meter #(
    .CNT_W       (W),
    .DEGLITCH_LEN(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .dmtd_in(dmtd_in),
    .meas   (mif),
    .overrun(overrun),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_res(input int p, input int h);
    q.push_back({16'd0, 8'(p), 8'(h)});
  endtask

  // Each tick drives one sample, changed 1 time unit after the rising edge.
  task automatic tick(input logic v);
    @(posedge clk);
    #1;
    dmtd_in = v;
  endtask

  task automatic seg(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic beat(input int h, input int l);
    seg(1'b1, h);
    seg(1'b0, l);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (overrun === 1'b1) ov_cnt++;
    if (timeout === 1'b1) to_cnt++;
    if (rst_n === 1'b1 && mif.meas_valid === 1'b1) begin
      chk("high_le_period", 32'(mif.meas_high <= mif.meas_period), 32'd1);
      if (mif.meas_ready === 1'b1) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_result observed=0x%0h expected=none",
                 {mif.meas_period, mif.meas_high});
        end
        if (q.size() != 0) begin
          chk("result", 32'({mif.meas_period, mif.meas_high}), q.pop_front());
          pops++;
        end
      end else if (q.size() != 0) begin
        chk("held_stable", 32'({mif.meas_period, mif.meas_high}), q[0]);
      end
    end
  end

  initial begin
    mif.meas_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(mif.meas_valid), 0);
    chk("rst_period", 32'(mif.meas_period), 0);
    chk("rst_high", 32'(mif.meas_high), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: clean square 100/30
    en = 1'b1;
    mif.meas_ready = 1'b1;
    seg(1'b0, 10);
    push_res(100, 30); beat(30, 70);
    push_res(100, 30); beat(30, 70);
    beat(30, 70);
    en = 1'b0;
    seg(1'b0, 5);
    chk("t1_pops", 32'(pops), 2);
    chk("t1_drained", 32'(q.size()), 0);

    // 2a: 2-cycle dip inside the high phase is filtered out
    en = 1'b1;
    push_res(100, 30); beat(30, 70);
    push_res(100, 30); seg(1'b1, 10); seg(1'b0, 2); seg(1'b1, 18); seg(1'b0, 70);
    beat(30, 70);
    en = 1'b0;
    seg(1'b0, 5);
    chk("t2a_pops", 32'(pops), 4);

    // 2b: 5-cycle dip passes and splits the period
    en = 1'b1;
    push_res(100, 30); beat(30, 70);
    push_res(15, 10); push_res(85, 15);
    seg(1'b1, 10); seg(1'b0, 5); seg(1'b1, 15); seg(1'b0, 70);
    beat(30, 70);
    en = 1'b0;
    seg(1'b0, 5);
    chk("t2b_pops", 32'(pops), 7);
    chk("t2b_drained", 32'(q.size()), 0);

    // 3: backpressure across three results
    mif.meas_ready = 1'b0;
    en = 1'b1;
    push_res(100, 20); beat(20, 80);
    beat(40, 60);
    beat(60, 40);
    beat(30, 70);
    en = 1'b0;
    chk("t3_overruns", 32'(ov_cnt), 2);
    chk("t3_valid_held", 32'(mif.meas_valid), 1);
    mif.meas_ready = 1'b1;
    seg(1'b0, 5);
    chk("t3_valid_clr", 32'(mif.meas_valid), 0);
    chk("t3_pops", 32'(pops), 8);

    // 4: accept and new result in the same cycle
    mif.meas_ready = 1'b0;
    en = 1'b1;
    push_res(100, 20); beat(20, 80);
    push_res(100, 50); beat(50, 50);
    seg(1'b1, 4);
    @(posedge clk);
    #1;
    dmtd_in = 1'b1;
    mif.meas_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_old", 32'(mif.meas_valid), 1);
    @(negedge clk);
    chk("t4_valid_kept", 32'(mif.meas_valid), 1);
    chk("t4_new_data", 32'({mif.meas_period, mif.meas_high}), 32'h6432);
    seg(1'b1, 24); seg(1'b0, 70);
    en = 1'b0;
    seg(1'b0, 5);
    chk("t4_pops", 32'(pops), 10);
    chk("t4_overruns", 32'(ov_cnt), 2);

    // 5: stuck-high beat saturates the period counter
    en = 1'b1;
    seg(1'b1, 259);
    @(negedge clk);
    @(negedge clk);
    chk("t5_timeout_early", 32'(timeout), 0);
    @(negedge clk);
    chk("t5_timeout_pulse", 32'(timeout), 1);
    @(negedge clk);
    chk("t5_timeout_end", 32'(timeout), 0);
    seg(1'b0, 10);
    push_res(100, 30); beat(30, 70);
    beat(30, 70);
    en = 1'b0;
    seg(1'b0, 5);
    chk("t5_timeouts", 32'(to_cnt), 1);
    chk("t5_pops", 32'(pops), 11);

    // 6a: async reset with a result pending
    mif.meas_ready = 1'b0;
    en = 1'b1;
    beat(20, 80);
    seg(1'b1, 30); seg(1'b0, 20);
    chk("t6_pending", 32'(mif.meas_valid), 1);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(mif.meas_valid), 0);
    chk("t6_rst_data", 32'({mif.meas_period, mif.meas_high}), 0);
    chk("t6_rst_pulses", 32'({overrun, timeout}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 6b: enable low keeps the pending result, restart needs two rises
    push_res(100, 20); beat(20, 80);
    seg(1'b1, 30); seg(1'b0, 20);
    en = 1'b0;
    seg(1'b0, 50); seg(1'b1, 30); seg(1'b0, 70);
    chk("t6_en_valid", 32'(mif.meas_valid), 1);
    chk("t6_en_overruns", 32'(ov_cnt), 2);
    chk("t6_en_pops", 32'(pops), 11);
    en = 1'b1;
    mif.meas_ready = 1'b1;
    push_res(100, 30); beat(30, 70);
    push_res(100, 45); beat(45, 55);
    beat(30, 70);
    en = 1'b0;
    seg(1'b0, 5);
    chk("final_pops", 32'(pops), 14);
    chk("final_drained", 32'(q.size()), 0);
    chk("final_overruns", 32'(ov_cnt), 2);
    chk("final_timeouts", 32'(to_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
